probe_display_ctrl: RTL and testbench
=====================================

# probe_display_ctrl

Parametrised, registered debug-probe output block for the 10-bit processor. It drives the bus LEDs, the timestep digit, a stretched DONE LED and a multi-digit hex display. The display shows the live bus, a register-file read port, or an on-chip history of bus values captured at each instruction completion. It sits beside the controller and register file and replaces the fixed-width combinational output logic.

## Interface
Parameters:
- DATA_W, 10, width of BUS/REG and of each history entry
- TIME_W, 2, width of TIME; legal range 1..4
- HIST_DEPTH, 8, number of history entries; power of two, ≥2
- STRETCH, 4, extra cycles LED_D stays lit after DONE falls; ≥0
- NDIG (localparam), ceil(DATA_W/4), number of data hex digits

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high
- BUS  in  DATA_W  shared data bus
- REG  in  DATA_W  register-file second read port
- TIME  in  TIME_W  controller timestep
- DONE  in  1  controller Clr, instruction complete
- Pkb  in  1  1 = show BUS, 0 = show REG (live mode)
- Hist  in  1  1 = history browse mode, overrides Pkb
- Step  in  1  browse-older request, level; rising edge acts
- LED_B  out  DATA_W  registered BUS
- DHEX  out  7*NDIG  digit k at [7k+6:7k], digit 0 = LS nibble
- THEX  out  7  decoded TIME
- LED_D  out  1  stretched DONE
- HIST_IDX  out  $clog2(HIST_DEPTH)  current browse offset (0 = newest)
- HIST_VLD  out  1  history holds ≥1 entry

## Operation
- Edge detect: done_q, step_q and hist_q are registered; rise = x & ~x_q.
- Capture: on DONE rise, hist[wr_ptr] <= BUS, wr_ptr++ (mod HIST_DEPTH), count saturates at HIST_DEPTH. Oldest entry is overwritten when full.
- Browse offset:
  - cleared to 0 on Hist rise.
  - On Step rise while Hist=1 and count>0: offset++, and it wraps to 0 after count-1.
  - Step is ignored when Hist=0.
  - Offset is always relative to the newest entry. A capture during browse shifts the view to the one-newer entry at the same offset.
- Display source, in priority order:
  - Hist=1 and count>0: hist[(wr_ptr-1-offset) mod HIST_DEPTH].
  - Hist=1 and count=0: all DHEX digits show segment pattern "-" (g only).
  - Hist=0: BUS when Pkb=1, REG when Pkb=0.
- Hex decode: each nibble maps 0-F to segments. Segments are active-low, ordered gfedcba. The top digit is zero-extended.
- THEX: TIME is zero-extended to 4 bits, then decoded the same way.
- LED_D: stretch counter is loaded with STRETCH while DONE=1 and decrements to 0 otherwise. LED_D = DONE_reg | (cnt≠0).
- Simultaneous DONE rise and Step rise: both act in the same cycle. The wrap test uses the pre-update count.

## Timing
- All outputs are registered, with 1-cycle latency from input to output. For history, the captured value is visible on the cycle after the write cycle's register, i.e. 2 cycles after the DONE rise.
- Reset (synchronous, active-high) sets:
  - wr_ptr=0, count=0, offset=0, cnt=0
  - edge registers =0
  - LED_B=0, DHEX=decode(0) on every digit, THEX=decode(0), LED_D=0, HIST_IDX=0, HIST_VLD=0
- History contents are not reset, but they are unreachable while count=0.
- Reset asserted mid-browse or mid-stretch: takes effect at the next edge, with no residual LED_D.
- DONE held high for many cycles captures exactly once. A Step held high advances exactly once.

## Structure
- Package probe_pkg holds:
  - SEG_DASH and the active-low segment constants
  - function hex_to_seg7(logic [3:0]) returning logic [6:0]
- Sub-module hex7seg wraps hex_to_seg7. It is instantiated NDIG+1 times via generate.
- The history is a flop array; no RAM inference is required.

## Test plan
- Reset, then BUS=10'h2A5, Pkb=1, Hist=0 → next cycle LED_B=10'h2A5 and DHEX digits show 5, A, 2. With Pkb=0, REG=10'h013 → digits show 3, 1, 0.
- TIME=2'd3 → THEX=decode(3). DONE pulsed for 1 cycle with STRETCH=4 → LED_D high for exactly 5 cycles.
- Capture BUS values 1, 2, 3 on three DONE pulses, then Hist=1 → shows 3 with HIST_IDX=0. Step, Step, Step → shows 2, then 1, then 3 again (wrap at count=3).
- Capture 10 values 0..9 with HIST_DEPTH=8, browse → newest is 9 and the oldest reachable is 2. The 8th Step returns to offset 0.
- Hist=1 with no captures → DHEX shows all dashes and HIST_VLD=0. Step has no effect.
- DONE rise and Step rise in the same cycle at offset 0 with count=2 → count becomes 3, offset becomes 1, display shows the previous newest.

Source files
------------

// File: rtl/probe_pkg.sv
// Shared constants and helpers for the debug-probe display block.
// Segment patterns are active-low, bit order gfedcba.
package probe_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_A    = 7'h08;
    localparam logic [6:0] SEG_B    = 7'h03;
    localparam logic [6:0] SEG_C    = 7'h46;
    localparam logic [6:0] SEG_D    = 7'h21;
    localparam logic [6:0] SEG_E    = 7'h06;
    localparam logic [6:0] SEG_F    = 7'h0E;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_DASH;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Single-digit combinational hex to seven-segment decoder.
module hex7seg
    import probe_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg7(nib_i);

endmodule

// File: rtl/probe_display_ctrl.sv
// Registered debug-probe outputs: bus LEDs, timestep digit, stretched DONE LED,
// and a hex display showing the live bus, a register port, or captured history.
module probe_display_ctrl
    import probe_pkg::*;
#(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned TIME_W     = 2,
    parameter int unsigned HIST_DEPTH = 8,
    parameter int unsigned STRETCH    = 4
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic [DATA_W-1:0]               BUS,
    input  logic [DATA_W-1:0]               REG,
    input  logic [TIME_W-1:0]               TIME,
    input  logic                            DONE,
    input  logic                            Pkb,
    input  logic                            Hist,
    input  logic                            Step,
    output logic [DATA_W-1:0]               LED_B,
    output logic [7*((DATA_W+3)/4)-1:0]     DHEX,
    output logic [6:0]                      THEX,
    output logic                            LED_D,
    output logic [$clog2(HIST_DEPTH)-1:0]   HIST_IDX,
    output logic                            HIST_VLD
);

    localparam int NDIG  = (DATA_W + 3) / 4;
    localparam int HEX_W = 4 * NDIG;
    localparam int IDX_W = $clog2(HIST_DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam int STR_W = (STRETCH > 0) ? $clog2(STRETCH + 1) : 1;

    logic              done_q, step_q, hist_q;
    logic              done_rise, step_rise, hist_rise;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  offset_q, offset_d;
    logic [STR_W-1:0]  str_q, str_d;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] disp_val;
    logic              show_dash;
    logic [DATA_W-1:0] hist_mem_q [HIST_DEPTH];

    logic [HEX_W+3:0]        nib_all;
    logic [7*(NDIG+1)-1:0]   seg_all;
    logic [DATA_W-1:0]       led_b_q;
    logic [7*NDIG-1:0]       dhex_q, dhex_d;
    logic [6:0]              thex_q;
    logic                    led_d_q, vld_q;

    // NOTE: every variable driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        done_rise = DONE & ~done_q;
        step_rise = Step & ~step_q;
        hist_rise = Hist & ~hist_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        offset_d  = offset_q;
        str_d     = str_q;

        if (done_rise) begin
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
            if (count_q != CNT_W'(HIST_DEPTH))
                count_d = count_q + CNT_W'(1);
        end

        // Wrap decision uses the pre-capture count even if DONE rises together.
        if (hist_rise)
            offset_d = '0;
        else if (step_rise && Hist && count_q != '0)
            offset_d = ({1'b0, offset_q} == count_q - CNT_W'(1)) ? '0 : offset_q + IDX_W'(1);

        if (DONE)
            str_d = STR_W'(STRETCH);
        else if (str_q != '0)
            str_d = str_q - STR_W'(1);

        rd_idx    = wr_ptr_q - IDX_W'(1) - offset_q;
        show_dash = Hist && (count_q == '0);
        if (Hist)
            disp_val = hist_mem_q[rd_idx];
        else
            disp_val = Pkb ? BUS : REG;

        nib_all = {4'(TIME), HEX_W'(disp_val)};
        dhex_d  = show_dash ? {NDIG{SEG_DASH}} : seg_all[7*NDIG-1:0];
    end

    // Data digits 0..NDIG-1 plus the timestep digit at index NDIG.
    for (genvar g = 0; g <= NDIG; g++) begin : g_dig
        hex7seg u_hex (
            .nib_i (nib_all[4*g +: 4]),
            .seg_o (seg_all[7*g +: 7])
        );
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            done_q   <= 1'b0;
            step_q   <= 1'b0;
            hist_q   <= 1'b0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            offset_q <= '0;
            str_q    <= '0;
            led_b_q  <= '0;
            dhex_q   <= {NDIG{SEG_0}};
            thex_q   <= SEG_0;
            led_d_q  <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            done_q   <= DONE;
            step_q   <= Step;
            hist_q   <= Hist;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            offset_q <= offset_d;
            str_q    <= str_d;
            led_b_q  <= BUS;
            dhex_q   <= dhex_d;
            thex_q   <= seg_all[7*NDIG +: 7];
            led_d_q  <= DONE | (str_q != '0);
            vld_q    <= (count_d != '0);
        end
    end

    // NOTE: the history array has no reset; entries are unreachable until
    // count_q says they were written, so clearing them would be wasted logic.
    always_ff @(posedge Clock) begin
        if (!Reset && done_rise)
            hist_mem_q[wr_ptr_q] <= BUS;
    end

    assign LED_B    = led_b_q;
    assign DHEX     = dhex_q;
    assign THEX     = thex_q;
    assign LED_D    = led_d_q;
    assign HIST_IDX = offset_q;
    assign HIST_VLD = vld_q;

endmodule

// File: tb/tb_probe_display_ctrl.sv
// Directed self-checking bench for probe_display_ctrl at default parameters.
module tb_probe_display_ctrl;

    logic        Clock = 1'b0;
    logic        Reset, DONE, Pkb, Hist, Step;
    logic [9:0]  BUS, REG;
    logic [1:0]  TIME;
    logic [9:0]  LED_B;
    logic [20:0] DHEX;
    logic [6:0]  THEX;
    logic        LED_D;
    logic [2:0]  HIST_IDX;
    logic        HIST_VLD;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [20:0] DASH3 = {3{7'h3F}};

    probe_display_ctrl dut (
        .Clock(Clock), .Reset(Reset), .BUS(BUS), .REG(REG), .TIME(TIME),
        .DONE(DONE), .Pkb(Pkb), .Hist(Hist), .Step(Step),
        .LED_B(LED_B), .DHEX(DHEX), .THEX(THEX), .LED_D(LED_D),
        .HIST_IDX(HIST_IDX), .HIST_VLD(HIST_VLD)
    );

    always #5 Clock = ~Clock;

    // Active-high gfedcba patterns written out by hand, inverted for the display.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] ah;
        case (n)
            4'h0: ah = 7'h3F; 4'h1: ah = 7'h06; 4'h2: ah = 7'h5B; 4'h3: ah = 7'h4F;
            4'h4: ah = 7'h66; 4'h5: ah = 7'h6D; 4'h6: ah = 7'h7D; 4'h7: ah = 7'h07;
            4'h8: ah = 7'h7F; 4'h9: ah = 7'h6F; 4'hA: ah = 7'h77; 4'hB: ah = 7'h7C;
            4'hC: ah = 7'h39; 4'hD: ah = 7'h5E; 4'hE: ah = 7'h79; default: ah = 7'h71;
        endcase
        return ~ah;
    endfunction

    function automatic logic [20:0] exp_hex(input logic [9:0] v);
        logic [11:0] x;
        x = {2'b00, v};
        return {seg7(x[11:8]), seg7(x[7:4]), seg7(x[3:0])};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic capture(input logic [9:0] v);
        BUS  = v;
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        tick();
    endtask

    task automatic step_once();
        Step = 1'b1;
        tick();
        Step = 1'b0;
        tick();
    endtask

    task automatic chk_hex(input string name, input logic [20:0] exp);
        n_checks++;
        if (DHEX !== exp) begin
            n_fail++;
            $display("FAIL %s: DHEX got %h expected %h", name, DHEX, exp);
        end
    endtask

    task automatic chk_idx(input string name, input logic [2:0] exp);
        n_checks++;
        if (HIST_IDX !== exp) begin
            n_fail++;
            $display("FAIL %s: HIST_IDX got %0d expected %0d", name, HIST_IDX, exp);
        end
    endtask

    task automatic test_reset();
        BUS = 10'h2A5; REG = 10'h1FF; TIME = 2'd3; DONE = 1'b1;
        Pkb = 1'b1; Hist = 1'b0; Step = 1'b0;
        Reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (LED_B !== 10'h000) begin n_fail++; $display("FAIL reset_led_b: got %h expected 000", LED_B); end
        chk_hex("reset_dhex", exp_hex(10'h000));
        n_checks++;
        if (THEX !== seg7(4'h0)) begin n_fail++; $display("FAIL reset_thex: got %h expected %h", THEX, seg7(4'h0)); end
        n_checks++;
        if (LED_D !== 1'b0) begin n_fail++; $display("FAIL reset_led_d: got %b expected 0", LED_D); end
        chk_idx("reset_idx", 3'd0);
        n_checks++;
        if (HIST_VLD !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", HIST_VLD); end
        DONE = 1'b0; TIME = 2'd0;
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_live();
        BUS = 10'h2A5; Pkb = 1'b1; Hist = 1'b0;
        tick();
        n_checks++;
        if (LED_B !== 10'h2A5) begin n_fail++; $display("FAIL live_led_b: got %h expected 2a5", LED_B); end
        chk_hex("live_bus", exp_hex(10'h2A5));
        Pkb = 1'b0; REG = 10'h013;
        tick();
        chk_hex("live_reg", exp_hex(10'h013));
        TIME = 2'd3;
        tick();
        n_checks++;
        if (THEX !== seg7(4'h3)) begin n_fail++; $display("FAIL thex_3: got %h expected %h", THEX, seg7(4'h3)); end
    endtask

    task automatic test_stretch();
        DONE = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) DONE = 1'b0;
            n_checks++;
            if (LED_D !== (i < 5)) begin
                n_fail++;
                $display("FAIL stretch_c%0d: LED_D got %b expected %b", i, LED_D, (i < 5));
            end
        end
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        n_checks++;
        if (LED_D !== 1'b0) begin n_fail++; $display("FAIL stretch_reset: LED_D got %b expected 0", LED_D); end
        Reset = 1'b0;
        tick();
        n_checks++;
        if (LED_D !== 1'b0) begin n_fail++; $display("FAIL stretch_residual: LED_D got %b expected 0", LED_D); end
    endtask

    task automatic test_empty_hist();
        do_reset();
        Hist = 1'b1;
        tick();
        chk_hex("empty_dash", DASH3);
        n_checks++;
        if (HIST_VLD !== 1'b0) begin n_fail++; $display("FAIL empty_vld: got %b expected 0", HIST_VLD); end
        step_once();
        chk_idx("empty_step_idx", 3'd0);
        chk_hex("empty_step_dash", DASH3);
        Hist = 1'b0;
        tick();
    endtask

    task automatic test_browse_wrap();
        do_reset();
        capture(10'd1);
        capture(10'd2);
        capture(10'd3);
        BUS = 10'h3FF;
        Hist = 1'b1;
        tick();
        chk_hex("browse_newest", exp_hex(10'd3));
        chk_idx("browse_idx0", 3'd0);
        n_checks++;
        if (HIST_VLD !== 1'b1) begin n_fail++; $display("FAIL browse_vld: got %b expected 1", HIST_VLD); end
        step_once();
        chk_hex("browse_s1", exp_hex(10'd2));
        chk_idx("browse_s1_idx", 3'd1);
        step_once();
        chk_hex("browse_s2", exp_hex(10'd1));
        step_once();
        chk_hex("browse_wrap", exp_hex(10'd3));
        chk_idx("browse_wrap_idx", 3'd0);
        // A held Step advances exactly once.
        Step = 1'b1;
        tick(); tick(); tick();
        Step = 1'b0;
        tick();
        chk_hex("browse_held_step", exp_hex(10'd2));
        chk_idx("browse_held_idx", 3'd1);
        Hist = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int v = 0; v < 10; v++) capture(10'(v));
        BUS = 10'h3FF;
        Hist = 1'b1;
        tick();
        chk_hex("ovf_newest", exp_hex(10'd9));
        for (int i = 1; i <= 8; i++) begin
            step_once();
            chk_hex($sformatf("ovf_step%0d", i), exp_hex((i == 8) ? 10'd9 : 10'(9 - i)));
            chk_idx($sformatf("ovf_idx%0d", i), 3'(i % 8));
        end
        Hist = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        capture(10'h011);
        capture(10'h022);
        BUS = 10'h033;
        Hist = 1'b1;
        tick();
        chk_hex("b2b_start", exp_hex(10'h022));
        DONE = 1'b1; Step = 1'b1;
        tick();
        DONE = 1'b0; Step = 1'b0;
        tick();
        chk_hex("b2b_same_cycle", exp_hex(10'h022));
        chk_idx("b2b_same_idx", 3'd1);
        // DONE held high across a BUS change captures only the first value.
        BUS = 10'h044; DONE = 1'b1;
        tick();
        BUS = 10'h055;
        tick(); tick();
        DONE = 1'b0;
        tick();
        chk_hex("b2b_shift_view", exp_hex(10'h033));
        step_once();
        chk_hex("b2b_off2", exp_hex(10'h022));
        step_once();
        chk_hex("b2b_off3", exp_hex(10'h011));
        step_once();
        chk_hex("b2b_wrap", exp_hex(10'h044));
        chk_idx("b2b_wrap_idx", 3'd0);
        step_once();
        Reset = 1'b1;
        tick();
        chk_idx("midbrowse_reset_idx", 3'd0);
        chk_hex("midbrowse_reset_dhex", exp_hex(10'h000));
        n_checks++;
        if (HIST_VLD !== 1'b0) begin n_fail++; $display("FAIL midbrowse_reset_vld: got %b expected 0", HIST_VLD); end
        Reset = 1'b0;
        tick();
        chk_hex("after_reset_dash", DASH3);
    endtask

    initial begin
        test_reset();
        test_live();
        test_stretch();
        test_empty_hist();
        test_browse_wrap();
        test_overflow();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
